// File: rtl/spart_pkg.sv
// spart_pkg: register addresses, status bit positions and reset divisor for the SPART bus controller
package spart_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_DB_LO  = 2'd2,
    ADDR_DB_HI  = 2'd3
  } addr_e;
  localparam int STAT_RDA = 0;
  localparam int STAT_TBR = 1;
  localparam int STAT_RXO = 2;
  localparam int STAT_TXO = 3;
  localparam int STAT_TXE = 4;
  localparam int STAT_IE_RXNE = 6;
  localparam int STAT_IE_TXE = 7;
  localparam logic [15:0] BAUD_RST_DEF = 16'd325;
endpackage

// File: rtl/spart_bus_ctrl_if.sv
// spart_bus_ctrl_if: processor bus control plus tx/rx/baud sideband; irq exists only with SPART_IRQ_EN
interface spart_bus_ctrl_if #(parameter int DATA_W = 8, parameter int BAUD_W = 16);
  logic              iocs;
  logic              iorw;
  logic [1:0]        ioaddr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BAUD_W-1:0] baud_div;
  logic              baud_load;
`ifdef SPART_IRQ_EN
  logic              irq;
  modport master(output iocs, iorw, ioaddr, rx_data, rx_valid, tx_ready,
                 input tx_data, tx_valid, baud_div, baud_load, irq);
  modport slave(input iocs, iorw, ioaddr, rx_data, rx_valid, tx_ready,
                output tx_data, tx_valid, baud_div, baud_load, irq);
`else
  modport master(output iocs, iorw, ioaddr, rx_data, rx_valid, tx_ready,
                 input tx_data, tx_valid, baud_div, baud_load);
  modport slave(input iocs, iorw, ioaddr, rx_data, rx_valid, tx_ready,
                output tx_data, tx_valid, baud_div, baud_load);
`endif
endinterface

// File: rtl/spart_fifo.sv
// spart_fifo: show-ahead FIFO; a push while full is accepted only when a pop frees a slot that cycle
module spart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rp];
  assign w_pop   = i_pop & !o_empty;
  assign w_push  = i_push & (!o_full | w_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: SPART processor-side bus controller with RX/TX FIFOs, atomic baud divisor and sticky flags
// Optional interrupt output and enables under `SPART_IRQ_EN.
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int BAUD_W   = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST = BAUD_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] databus,
  spart_bus_ctrl_if.slave   bus
);
  addr_e                     w_addr;
  logic                      w_rd, w_wr, w_st_wr, w_hi_wr;
  logic                      w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
  logic                      w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_drop;
  logic [DATA_W-1:0]         w_rx_head, w_stat, w_rdata;
  logic [$clog2(RX_DEPTH):0] w_rx_cnt;
  logic [$clog2(TX_DEPTH):0] w_tx_cnt;
  logic                      r_rx_ovf, r_tx_ovf, r_load;
  logic [DATA_W-1:0]         r_stage;
  logic [BAUD_W-1:0]         r_baud;
  logic [1:0]                w_ie;
  assign w_addr     = addr_e'(bus.ioaddr);
  assign w_rd       = bus.iocs & bus.iorw;
  assign w_wr       = bus.iocs & !bus.iorw;
  assign w_st_wr    = w_wr && w_addr == ADDR_STATUS;
  assign w_hi_wr    = w_wr && w_addr == ADDR_DB_HI;
  assign w_rx_pop   = w_rd && w_addr == ADDR_DATA && !w_rx_empty;
  assign w_rx_drop  = bus.rx_valid & w_rx_full & !w_rx_pop;
  assign w_tx_push  = w_wr && w_addr == ADDR_DATA;
  assign w_tx_pop   = !w_tx_empty & bus.tx_ready;
  assign w_tx_drop  = w_tx_push & w_tx_full & !w_tx_pop;
  spart_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .i_push(bus.rx_valid), .i_pop(w_rx_pop), .i_data(bus.rx_data),
    .o_data(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_cnt));
  spart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(databus),
    .o_data(bus.tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_cnt));
  always_comb begin
    w_stat                  = '0;
    w_stat[STAT_RDA]        = !w_rx_empty;
    w_stat[STAT_TBR]        = !w_tx_full;
    w_stat[STAT_RXO]        = r_rx_ovf;
    w_stat[STAT_TXO]        = r_tx_ovf;
    w_stat[STAT_TXE]        = w_tx_empty;
    w_stat[STAT_IE_RXNE]    = w_ie[0];
    w_stat[STAT_IE_TXE]     = w_ie[1];
  end
  assign w_rdata = w_addr == ADDR_DATA   ? (w_rx_empty ? '0 : w_rx_head) :
                   w_addr == ADDR_STATUS ? w_stat :
                   w_addr == ADDR_DB_LO  ? r_stage : r_baud[BAUD_W-1:DATA_W];
  assign databus       = w_rd ? w_rdata : 'z;
  assign bus.tx_valid  = !w_tx_empty;
  assign bus.baud_div  = r_baud;
  assign bus.baud_load = r_load;
  // a same-cycle overflow wins over the write-1-to-clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_stage  <= '0;
      r_baud   <= BAUD_RST;
      r_load   <= 1'b0;
    end else begin
      r_rx_ovf <= w_rx_drop | (r_rx_ovf & !(w_st_wr & databus[STAT_RXO]));
      r_tx_ovf <= w_tx_drop | (r_tx_ovf & !(w_st_wr & databus[STAT_TXO]));
      if (w_wr && w_addr == ADDR_DB_LO) r_stage <= databus;
      if (w_hi_wr) r_baud <= {databus, r_stage};
      r_load <= w_hi_wr;
    end
  always_ff @(posedge clk)
    if (rst_n) assert (w_rx_cnt <= ($clog2(RX_DEPTH)+1)'(RX_DEPTH) && w_tx_cnt <= ($clog2(TX_DEPTH)+1)'(TX_DEPTH));
`ifdef SPART_IRQ_EN
  logic [1:0] r_ie;
  logic       r_irq;
  assign w_ie    = r_ie;
  assign bus.irq = r_irq;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ie  <= 2'b00;
      r_irq <= 1'b0;
    end else begin
      if (w_st_wr) r_ie <= {databus[STAT_IE_TXE], databus[STAT_IE_RXNE]};
      r_irq <= (r_ie[0] & !w_rx_empty) | (r_ie[1] & w_tx_empty) | r_rx_ovf | r_tx_ovf;
    end
`else
  assign w_ie = 2'b00;
`endif
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl: directed vectors for the SPART bus controller with hand-computed expectations
module tb_spart_bus_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] databus;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  logic [7:0] d;
  int         n_chk = 0;
  int         n_err = 0;
  assign databus = drv_en ? drv : 'z;
  spart_bus_ctrl_if #(.DATA_W(8), .BAUD_W(16)) bus();
  spart_bus_ctrl #(.DATA_W(8), .RX_DEPTH(8), .TX_DEPTH(8), .BAUD_W(16), .BAUD_RST(16'd325)) dut (
    .clk(clk), .rst_n(rst_n), .databus(databus), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; drv = v; drv_en = 1'b1;
    @(posedge clk);
    #1 bus.iocs = 1'b0; drv_en = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #1 v = databus;
    @(posedge clk);
    #1 bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(tag, {24'h0, v}, {24'h0, exp});
  endtask
  task automatic rx_push(input logic [7:0] v);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = v;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask
  initial begin
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'd0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    #12;
    chk("rst_baud", 32'(bus.baud_div), 32'd325);
    chk("rst_txv", 32'(bus.tx_valid), 32'd0);
    chk("rst_load", 32'(bus.baud_load), 32'd0);
    rst_n = 1'b1;
    rd_chk("rst_stat", 2'd1, 8'h12);
    wr(2'd2, 8'h46);
    rd_chk("stage_lo", 2'd2, 8'h46);
    chk("baud_hold", 32'(bus.baud_div), 32'd325);
    wr(2'd3, 8'h01);
    chk("baud_new", 32'(bus.baud_div), 32'h0146);
    chk("load_hi", 32'(bus.baud_load), 32'd1);
    @(posedge clk); #1;
    chk("load_lo", 32'(bus.baud_load), 32'd0);
    rd_chk("baud_hi", 2'd3, 8'h01);
    for (int i = 0; i < 9; i++) rx_push(8'(8'hA0 + i));
    rd_chk("rx_ovf_stat", 2'd1, 8'h17);
    for (int i = 0; i < 8; i++) rd_chk("rx_data", 2'd0, 8'(8'hA0 + i));
    rd_chk("rx_empty_rd", 2'd0, 8'h00);
    rd_chk("rx_empty_stat", 2'd1, 8'h16);
    wr(2'd1, 8'h04);
    rd_chk("rx_ovf_clr", 2'd1, 8'h12);
    for (int i = 0; i < 9; i++) wr(2'd0, 8'(8'h10 + i));
    rd_chk("tx_full_stat", 2'd1, 8'h08);
    chk("tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("tx_head", 32'(bus.tx_data), 32'h10);
    bus.tx_ready = 1'b1;
    wr(2'd0, 8'h19);
    for (int i = 0; i < 8; i++) begin
      chk("tx_seq", 32'(bus.tx_data), i < 7 ? 32'h11 + 32'(i) : 32'h19);
      @(posedge clk); #1;
    end
    chk("tx_drained", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;
    rd_chk("tx_done_stat", 2'd1, 8'h1A);
    for (int i = 0; i < 8; i++) rx_push(8'(8'hB0 + i));
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'd0; bus.rx_valid = 1'b1; bus.rx_data = 8'hB8;
    #1 d = databus;
    @(posedge clk);
    #1 bus.iocs = 1'b0; bus.iorw = 1'b0; bus.rx_valid = 1'b0;
    chk("rx_pop_push", 32'(d), 32'hB0);
    rd_chk("rx_no_ovf", 2'd1, 8'h1B);
    chk("rx_count", 32'(dut.w_rx_cnt), 32'd8);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'd1; drv = 8'h0C; drv_en = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'hB9;
    @(posedge clk);
    #1 bus.iocs = 1'b0; drv_en = 1'b0; bus.rx_valid = 1'b0;
    rd_chk("set_beats_clr", 2'd1, 8'h17);
`ifdef SPART_IRQ_EN
    wr(2'd1, 8'h04);
    @(posedge clk); #1;
    chk("irq_off", 32'(bus.irq), 32'd0);
    wr(2'd1, 8'h40);
    chk("irq_lat", 32'(bus.irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_on", 32'(bus.irq), 32'd1);
    rd_chk("ie_stat", 2'd1, 8'h53);
`else
    wr(2'd1, 8'hC4);
    rd_chk("ie_ignored", 2'd1, 8'h13);
`endif
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'd3; drv = 8'h77; drv_en = 1'b1;
    @(posedge clk); #1;
    chk("idle_load", 32'(bus.baud_load), 32'd0);
    chk("idle_baud", 32'(bus.baud_div), 32'h0146);
    drv_en = 1'b0;
    wr(2'd2, 8'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_baud", 32'(bus.baud_div), 32'd325);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_stat", 2'd1, 8'h12);
    rd_chk("post_rst_stage", 2'd2, 8'h00);
    wr(2'd3, 8'h02);
    chk("stage_discard", 32'(bus.baud_div), 32'h0200);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
